// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the fetch PC, holds the ID-stage instruction and
// parks one returned word in a skid buffer when decode stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic        jump,
    input  logic [15:0] branch_off,
    input  logic [25:0] jump_idx,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc_plus4
);

    typedef enum logic [0:0] {
        FETCH    = 1'b0,
        BUFFERED = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pp4_q;
    logic [31:0] skid_q;
    logic [31:0] skid_pp4_q;
    logic        valid_q;
    logic        req_q;

    logic        consume_s;
    logic        redirect_s;
    logic        done_s;
    logic        accept_s;
    logic [31:0] pc_inc_s;
    logic [31:0] target_s;

    // Handshake qualifiers and the redirect target of the held instruction
    always_comb begin
        consume_s  = valid_q && !stall;
        redirect_s = consume_s && (jump || pc_src);
        done_s     = req_q && imem_ready;
        accept_s   = !valid_q || consume_s;
        pc_inc_s   = pc_q + 32'd4;
        if (jump) begin
            target_s = {pp4_q[31:28], jump_idx, 2'b00};
        end else begin
            target_s = pp4_q + {{14{branch_off[15]}}, branch_off, 2'b00};
        end
    end

    // Fetch FSM; imem_req is registered so it stays low for the whole reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            pp4_q      <= 32'h0000_0000;
            skid_q     <= 32'h0000_0000;
            skid_pp4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    req_q <= 1'b1;
                    if (redirect_s) begin
                        // Any word completing this cycle is from the wrong path
                        pc_q    <= target_s;
                        valid_q <= 1'b0;
                    end else if (done_s && accept_s) begin
                        instr_q <= imem_rdata;
                        pp4_q   <= pc_inc_s;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_s;
                    end else if (done_s) begin
                        skid_q     <= imem_rdata;
                        skid_pp4_q <= pc_inc_s;
                        pc_q       <= pc_inc_s;
                        state_q    <= BUFFERED;
                        req_q      <= 1'b0;
                    end else if (consume_s) begin
                        valid_q <= 1'b0;
                    end
                end
                BUFFERED: begin
                    if (redirect_s) begin
                        pc_q    <= target_s;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end else if (consume_s) begin
                        instr_q <= skid_q;
                        pp4_q   <= skid_pp4_q;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    valid_q <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc_plus4    = pp4_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request; imem_addr valid while high.
REQ-005 imem_addr  output  32  word address of the fetch (bits [1:0] always 0).
REQ-006 imem_ready  input  1  fetch completes in a cycle where imem_req && imem_ready.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-008 stall  input  1  decode stage cannot accept the held instruction this cycle.
REQ-009 pc_src  input  1  branch taken for the held instruction (branch & zero_flag).
REQ-010 jump  input  1  jump for the held instruction.
REQ-011 branch_off  input  16  signed word offset of the held instruction (instr[15:0]).
REQ-012 jump_idx  input  26  jump index of the held instruction (instr[25:0]).
REQ-013 instr  output  32  held instruction (ID register).
REQ-014 opcode  output  6  instr[31:26]; funct  output  6  instr[5:0].
REQ-015 instr_valid  output  1  instr holds a live instruction.
REQ-016 pc_plus4  output  32  address of held instruction + 4.

Function
REQ-017 Consume = instr_valid && !stall; redirect = consume && (jump || pc_src); pc_src, jump, branch_off, jump_idx are ignored unless consume is high.
REQ-018 Redirect target: jump -> {pc_plus4[31:28], jump_idx, 2'b00}; else pc_src -> pc_plus4 + sign-extended branch_off shifted left 2, mod 2^32; jump has priority over pc_src.
REQ-019 Internal fetch PC increments by 4 mod 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000); imem_addr = fetch PC.
REQ-020 ID register accepts new data when !instr_valid || consume.
REQ-021 FSM states FETCH and BUFFERED; one-entry skid buffer (data + its pc_plus4).
REQ-022 FETCH: imem_req = 1.
REQ-023 FETCH, fetch completes, redirect: drop rdata, fetch PC <= target, instr_valid <= 0, stay FETCH.
REQ-024 FETCH, fetch completes, no redirect, accept: instr <= imem_rdata, pc_plus4 <= fetch PC + 4, instr_valid <= 1, fetch PC += 4, stay FETCH.
REQ-025 FETCH, fetch completes, no accept: rdata and fetch PC + 4 into skid, fetch PC += 4, go BUFFERED.
REQ-026 FETCH, no completion, redirect: fetch PC <= target, instr_valid <= 0; imem_req stays high with the new address (memory tolerates address change while not ready).
REQ-027 FETCH, no completion, consume without redirect: instr_valid <= 0.
REQ-028 BUFFERED: imem_req = 0; stall -> hold everything; redirect -> discard skid, fetch PC <= target, instr_valid <= 0, go FETCH; consume without redirect -> skid moves to ID register, instr_valid stays 1, go FETCH.
REQ-029 Fetch-to-instr_valid latency: one edge after the completing cycle; back-to-back, one instruction per cycle with imem_ready held high and stall low.
REQ-030 No instruction is ever duplicated, skipped, or delivered after a redirect from the wrong path.

Reset
REQ-031 rst_n low asynchronously forces: state FETCH, fetch PC = RESET_PC, instr = 0, pc_plus4 = 0, instr_valid = 0, skid cleared; imem_req = 0 while rst_n low.
REQ-032 First rising edge with rst_n high: imem_req = 1, imem_addr = RESET_PC; reset mid-fetch abandons the request with no delivery.

Verification
REQ-033 Reset release, imem_ready = 1, rdata = addr-tagged words, stall = 0 -> imem_addr 0,4,8,12 on consecutive cycles; instr follows one cycle later; pc_plus4 = 4,8,12.
REQ-034 Stall high 3 cycles while instr@4 held and fetch@8 completes -> BUFFERED, imem_req = 0, instr stays @4; stall low -> instr@8 next cycle, fetch resumes at 12, nothing lost.
REQ-035 Held instr pc_plus4 = 32'h0000_0010, pc_src = 1, branch_off = 16'hFFFE -> next imem_addr = 32'h0000_0008; concurrent fetch data dropped; instr_valid low one cycle.
REQ-036 pc_plus4 = 32'h4000_0008, jump = 1 and pc_src = 1, jump_idx = 26'h000_0100 -> imem_addr = 32'h4000_0400 (jump wins).
REQ-037 RESET_PC = 32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-038 rst_n pulsed low mid-fetch with imem_ready = 0 -> all outputs at REQ-031 values immediately, without waiting for a clock edge; refetch from RESET_PC.
